sw_prio_encoder: RTL and testbench

Upstream feeder for the 7-segment digit decoder. It samples 8 slide switches and one enable switch, then synchronises and debounces them. It priority-encodes the stable switch vector into a 3-bit index and outputs a registered enable/valid pair. Its outputs drive the decoder's en and data inputs directly. It also emits a one-cycle change pulse for LED or status logic.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/sw_prio_encoder.sv | 75 +++++++
 tb/tb_sw_prio_encoder.sv | 117 +++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared widths and sample type for the switch feeder and 7-segment decoder.
package seg_pkg;

    localparam int unsigned SW_W   = 8;
    localparam int unsigned CODE_W = 3;

    typedef struct packed {
        logic            en;
        logic [SW_W-1:0] sw;
    } sample_t;

    // Index of the highest set bit; 0 when no bit is set.
    function automatic logic [CODE_W-1:0] prio_enc(input logic [SW_W-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < SW_W; i++) begin
            if (v[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, width-parameterised.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            q     <= '0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end

endmodule

// File: rtl/sw_prio_encoder.sv
// Synchronises and debounces {en,sw}, then priority-encodes the stable switch
// vector into a registered code/valid pair with a one-cycle change pulse.
module sw_prio_encoder
    import seg_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   sw_in,
    input  logic              en_in,
    output logic [CODE_W-1:0] code_o,
    output logic              valid_o,
    output logic              changed_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    sample_t          raw;
    sample_t          sync2;
    sample_t          cand;
    sample_t          stable;
    logic [CNT_W-1:0] cnt;
    logic             commit;
    logic             commit_q;
    logic             valid_nxt;

    assign raw = '{en: en_in, sw: sw_in};

    sync_2ff #(
        .W($bits(sample_t))
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw),
        .q   (sync2)
    );

    assign commit    = (cnt == CNT_MAX) && (sync2 == cand) && (cand != stable);
    assign valid_nxt = stable.en & (|stable.sw);

    always_ff @(posedge clk) begin
        if (rst) begin
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (commit) stable <= cand;
        end
    end

    // The pulse is delayed one extra stage so it lines up with the
    // encoder outputs, which are registered from stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_q  <= 1'b0;
            changed_o <= 1'b0;
            valid_o   <= 1'b0;
            code_o    <= '0;
        end else begin
            commit_q  <= commit;
            changed_o <= commit_q;
            valid_o   <= valid_nxt;
            code_o    <= valid_nxt ? prio_enc(stable.sw) : '0;
        end
    end

endmodule

// File: tb/tb_sw_prio_encoder.sv
// Directed-vector bench for sw_prio_encoder with DEBOUNCE_CYCLES=4.
module tb_sw_prio_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_in;
    logic       en_in;
    logic [2:0] code_o;
    logic       valid_o;
    logic       changed_o;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    sw_prio_encoder #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .en_in     (en_in),
        .code_o    (code_o),
        .valid_o   (valid_o),
        .changed_o (changed_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] c, input logic v, input logic ch);
        chk({tag, ".code"}, 32'(code_o), 32'(c));
        chk({tag, ".valid"}, 32'(valid_o), 32'(v));
        chk({tag, ".changed"}, 32'(changed_o), 32'(ch));
    endtask

    // Apply a new input level, then check the commit lands exactly 7 edges on
    // (DEBOUNCE_CYCLES+3) with a single-cycle changed pulse.
    task automatic apply(input string tag, input logic e, input logic [7:0] s,
                         input logic [2:0] c_old, input logic v_old,
                         input logic [2:0] c_new, input logic v_new);
        en_in = e;
        sw_in = s;
        tick(7);
        chk_out({tag, "@E+6"}, c_old, v_old, 1'b0);
        tick(1);
        chk_out({tag, "@E+7"}, c_new, v_new, 1'b1);
        tick(1);
        chk_out({tag, "@E+8"}, c_new, v_new, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        sw_in = 8'hFF;
        en_in = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick(1);
            chk_out("reset", 3'd0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        tick(1);
        chk_out("post_release", 3'd0, 1'b0, 1'b0);
        sw_in = 8'h00;
        en_in = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            tick(1);
            chk_out("settle_zero", 3'd0, 1'b0, 1'b0);
        end

        apply("basic",  1'b1, 8'b0001_0100, 3'd0, 1'b0, 3'd4, 1'b1);
        apply("prio7",  1'b1, 8'b1000_0101, 3'd4, 1'b1, 3'd7, 1'b1);
        apply("prio0",  1'b1, 8'h01,        3'd7, 1'b1, 3'd0, 1'b1);

        apply("g_setup", 1'b1, 8'h04, 3'd0, 1'b1, 3'd2, 1'b1);
        sw_in = 8'h80;
        tick(2);
        sw_in = 8'h04;
        for (int unsigned i = 0; i < 12; i++) begin
            tick(1);
            chk_out("glitch", 3'd2, 1'b1, 1'b0);
        end

        apply("en_setup", 1'b1, 8'h40, 3'd2, 1'b1, 3'd6, 1'b1);
        apply("en_off",   1'b0, 8'h40, 3'd6, 1'b1, 3'd0, 1'b0);
        apply("en_on",    1'b1, 8'h40, 3'd0, 1'b0, 3'd6, 1'b1);

        sw_in = 8'h08;
        tick(3);
        rst = 1'b1;
        tick(1);
        chk_out("mid_rst", 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(7);
        chk_out("rel@E+6", 3'd0, 1'b0, 1'b0);
        tick(1);
        chk_out("rel@E+7", 3'd3, 1'b1, 1'b1);
        tick(1);
        chk_out("rel@E+8", 3'd3, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
